// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the io_port_ctrl register window.
//   - Register offsets, selected by adr[3:2].
//   - Bit positions inside the STATUS and CTRL words.
//   - status_word_t, the type of the 32-bit STATUS read value.
// The CTRL constants are used only when IO_PORT_IRQ_EN is defined.

package io_port_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;

    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_UNDERFLOW = 4;
    localparam int ST_TX_OVERFLOW  = 5;
    localparam int ST_RX_COUNT_LSB = 8;

    localparam int CTRL_RX_IE       = 0;
    localparam int CTRL_TX_EMPTY_IE = 1;
    localparam int CTRL_ERR_IE      = 2;
    localparam int CTRL_W           = 3;

    typedef logic [31:0] status_word_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy count.
//   clk, reset_n        clock and asynchronous active-low reset
//   push, din           write request and write data
//   pop, dout           read request and head data (dout is 0 while empty)
//   full, empty, count  occupancy flags; count is log2(DEPTH)+1 bits
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gating dout on empty keeps the external side at 0 right after reset.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array has no reset. Reads are masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped byte I/O port on the CPU data bus.
//   clk, reset_n                  clock and asynchronous active-low reset
//   adr, we, re, wd, rd, sel      CPU bus; rd is combinational and 0 unless sel
//   in_data/in_valid/in_ready     producer side, feeds the RX FIFO
//   out_data/out_valid/out_ready  consumer side, fed from the TX FIFO
//   irq                           registered interrupt (IO_PORT_IRQ_EN only)
// Register window at BASE_ADR:
//   +0x0  DATA
//   +0x4  STATUS
//   +0x8  CTRL (IO_PORT_IRQ_EN only; otherwise reserved)
// Optional feature macro: IO_PORT_IRQ_EN adds the CTRL register and the irq output.

module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h800,
    parameter int          WIDTH    = 8,
    parameter int          DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      adr,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef IO_PORT_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             hit, sel_data, sel_status, sel_ctrl;
    logic [1:0]       ofs;
    logic             data_rd, data_wr, status_wr;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [WIDTH-1:0] rx_dout, tx_dout;
    logic [CW-1:0]    rx_count, unused_tx_count;
    logic             rx_underflow_q, rx_underflow_d;
    logic             tx_overflow_q, tx_overflow_d;
    status_word_t     status;
    logic             unused_wd;

    assign hit        = (adr[31:4] == BASE_ADR[31:4]) && (adr[1:0] == 2'b00);
    assign ofs        = adr[3:2];
    assign sel_data   = hit && (ofs == OFS_DATA);
    assign sel_status = hit && (ofs == OFS_STATUS);
`ifdef IO_PORT_IRQ_EN
    assign sel_ctrl   = hit && (ofs == OFS_CTRL);
`else
    assign sel_ctrl   = 1'b0;
`endif
    assign sel        = sel_data | sel_status | sel_ctrl;

    assign data_rd    = re && sel_data;
    assign data_wr    = we && sel_data;
    assign status_wr  = we && sel_status;

    assign in_ready   = !rx_full;
    assign rx_push    = in_valid && in_ready;
    assign rx_pop     = data_rd && !rx_empty;

    assign out_valid  = !tx_empty;
    assign out_data   = tx_dout;
    assign tx_pop     = out_valid && out_ready;
    // A consumer pop in the same cycle frees the slot, so a write to a full TX FIFO still lands.
    assign tx_push    = data_wr && (!tx_full || tx_pop);

    assign unused_wd  = ^wd;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .din     (in_data),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .din     (wd[WIDTH-1:0]),
        .dout    (tx_dout),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (unused_tx_count)
    );

    // Setting a sticky flag takes priority over clearing it in the same cycle.
    always_comb begin
        rx_underflow_d = rx_underflow_q;
        tx_overflow_d  = tx_overflow_q;
        if (status_wr && wd[ST_RX_UNDERFLOW]) rx_underflow_d = 1'b0;
        if (status_wr && wd[ST_TX_OVERFLOW])  tx_overflow_d  = 1'b0;
        if (data_rd && rx_empty)              rx_underflow_d = 1'b1;
        if (data_wr && !tx_push)              tx_overflow_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_underflow_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
        end else begin
            rx_underflow_q <= rx_underflow_d;
            tx_overflow_q  <= tx_overflow_d;
        end
    end

    always_comb begin
        status                          = '0;
        status[ST_RX_NONEMPTY]          = !rx_empty;
        status[ST_RX_FULL]              = rx_full;
        status[ST_TX_EMPTY]             = tx_empty;
        status[ST_TX_FULL]              = tx_full;
        status[ST_RX_UNDERFLOW]         = rx_underflow_q;
        status[ST_TX_OVERFLOW]          = tx_overflow_q;
        status[ST_RX_COUNT_LSB +: CW]   = rx_count;
    end

`ifdef IO_PORT_IRQ_EN
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              irq_q, irq_d;

    always_comb begin
        ctrl_d = ctrl_q;
        if (we && sel_ctrl) ctrl_d = wd[CTRL_W-1:0];
        irq_d = (ctrl_q[CTRL_RX_IE]       && !rx_empty)
              | (ctrl_q[CTRL_TX_EMPTY_IE] && tx_empty)
              | (ctrl_q[CTRL_ERR_IE]      && (rx_underflow_q || tx_overflow_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd = '0;
        if (sel_data)
            rd[WIDTH-1:0] = rx_dout;
        else if (sel_status)
            rd = status;
`ifdef IO_PORT_IRQ_EN
        else if (sel_ctrl)
            rd[CTRL_W-1:0] = ctrl_q;
`endif
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

    localparam logic [31:0] BASE   = 32'h800;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam int          DEPTH  = 4;
`ifdef IO_PORT_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] adr, wd, rd;
    logic        we, re, sel;
    logic [7:0]  in_data, out_data;
    logic        in_valid, in_ready, out_valid, out_ready;
`ifdef IO_PORT_IRQ_EN
    logic        irq;
`endif

    io_port_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .adr       (adr),
        .we        (we),
        .re        (re),
        .wd        (wd),
        .rd        (rd),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef IO_PORT_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  rx_model[$];
    logic [7:0]  tx_model[$];
    logic [31:0] exp_q[$];
    logic        ux_model = 1'b0;
    logic        ox_model = 1'b0;
    logic [2:0]  ctrl_model = 3'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0]    = (rx_model.size() != 0);
        s[1]    = (rx_model.size() == DEPTH);
        s[2]    = (tx_model.size() == 0);
        s[3]    = (tx_model.size() == DEPTH);
        s[4]    = ux_model;
        s[5]    = ox_model;
        s[10:8] = 3'(rx_model.size());
        return s;
    endfunction

    function automatic logic hit_of(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic sel_of(input logic [31:0] a);
        return hit_of(a) && (a[3:2] == 2'd0 || a[3:2] == 2'd1 || (HAS_IRQ && a[3:2] == 2'd2));
    endfunction

    // Producer/consumer monitor: runs after the stimulus of each cycle is settled.
    always begin
        @(negedge clk);
        #3;
        if (reset_n) begin
            if (in_valid && in_ready) rx_model.push_back(in_data);
            if (out_valid && out_ready) begin
                if (tx_model.size() == 0) check("tx_unexpected_valid", {31'b0, out_valid}, 32'h0);
                else check("tx_data", {24'b0, out_data}, {24'b0, tx_model.pop_front()});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        re = 1'b0; we = 1'b0; adr = '0; wd = '0;
    endtask

    task automatic cpu_rd(input logic [31:0] a, input string tag);
        logic [31:0] e;
        adr = a; re = 1'b1; we = 1'b0;
        e = '0;
        if (sel_of(a)) begin
            case (a[3:2])
                2'd0: begin
                    if (rx_model.size() == 0) ux_model = 1'b1;
                    else e = {24'b0, rx_model.pop_front()};
                end
                2'd1:    e = model_status();
                2'd2:    e = {29'b0, ctrl_model};
                default: e = '0;
            endcase
        end
        exp_q.push_back(e);
        #2;
        check({tag, "_sel"}, {31'b0, sel}, {31'b0, sel_of(a)});
        check(tag, rd, exp_q.pop_front());
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        adr = a; wd = d; we = 1'b1; re = 1'b0;
        if (sel_of(a)) begin
            case (a[3:2])
                2'd0: begin
                    if (tx_model.size() < DEPTH || (out_ready && tx_model.size() != 0))
                        tx_model.push_back(d[7:0]);
                    else
                        ox_model = 1'b1;
                end
                2'd1: begin
                    if (d[4]) ux_model = 1'b0;
                    if (d[5]) ox_model = 1'b0;
                end
                2'd2:    ctrl_model = d[2:0];
                default: ;
            endcase
        end
        #2;
    endtask

    task automatic drain_tx(input string tag);
        int budget;
        budget = 20;
        out_ready = 1'b1;
        while (tx_model.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 32'(tx_model.size()), 32'h0);
        tick();
        #2 check({tag, "_out_valid_low"}, {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; re = 1'b0; we = 1'b0; adr = '0; wd = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_in_ready",  {31'b0, in_ready},  32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data",  {24'b0, out_data},  32'h0);
        check("rst_rd",        rd,                 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single byte: STATUS shows one entry (tx_empty also set), then DATA pops it.
        tick(); in_data = 8'hA5; in_valid = 1'b1;
        tick(); in_valid = 1'b0; cpu_rd(A_STAT, "t1_status");
        check("t1_status_const", rd, 32'h105);
        tick(); cpu_rd(A_DATA, "t1_data");
        check("t1_data_const", rd, 32'hA5);
        tick(); cpu_rd(A_STAT, "t1_status_after");
        check("t1_status_after_const", rd, 32'h004);

        // Back-pressure: five bytes offered, four fit.
        for (int i = 1; i <= 4; i++) begin
            tick(); in_data = 8'(i); in_valid = 1'b1;
        end
        tick(); in_data = 8'h05; cpu_rd(A_STAT, "t2_status_full");
        check("t2_in_ready_full", {31'b0, in_ready}, 32'h0);
        tick(); cpu_rd(A_DATA, "t2_data_first");
        check("t2_in_ready_during_pop", {31'b0, in_ready}, 32'h0);
        tick(); cpu_rd(A_STAT, "t2_status_after_pop");
        check("t2_in_ready_after_pop", {31'b0, in_ready}, 32'h1);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_rd(A_DATA, "t2_data");
            tick();
        end
        cpu_rd(A_STAT, "t2_status_empty");

        // Underflow sticky and clear.
        tick(); cpu_rd(A_DATA, "t3_data_empty");
        tick(); cpu_rd(A_STAT, "t3_status_ux");
        check("t3_status_ux_const", rd, 32'h014);
        tick(); cpu_wr(A_STAT, 32'h10);
        tick(); cpu_rd(A_STAT, "t3_status_cleared");

        // Push into empty RX with a DATA read in the same cycle.
        tick(); in_data = 8'h5A; in_valid = 1'b1; cpu_rd(A_DATA, "t3b_data_race");
        tick(); in_valid = 1'b0; cpu_rd(A_STAT, "t3b_status");
        tick(); cpu_rd(A_DATA, "t3b_data");
        tick(); cpu_wr(A_STAT, 32'h10);

        // TX overflow, then drain.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(); cpu_wr(A_DATA, 32'(8'h11 * i));
        end
        tick(); cpu_rd(A_STAT, "t4_status_full_ovf");
        check("t4_status_const", rd, 32'h028);
        drain_tx("t4_drain");
        tick(); cpu_wr(A_STAT, 32'h20);

        // TX full + consumer pop + CPU write in the same cycle: no overflow.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); cpu_wr(A_DATA, 32'hA0 + 32'(i));
        end
        tick(); out_ready = 1'b1; cpu_wr(A_DATA, 32'h66);
        tick(); out_ready = 1'b0; cpu_rd(A_STAT, "t4b_status");
        check("t4b_status_const", rd, 32'h008);
        drain_tx("t4b_drain");

        // Undefined addresses: no select, no data, no side effects.
        tick(); in_data = 8'h77; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); cpu_wr(32'h80C, 32'h99);
        tick(); cpu_rd(32'h80C, "t5_rd_80c");
        tick(); cpu_wr(32'h900, 32'h99);
        tick(); cpu_rd(32'h900, "t5_rd_900");
        tick(); cpu_rd(32'h801, "t5_rd_801");
        if (!HAS_IRQ) begin
            tick(); cpu_wr(A_CTRL, 32'h7);
            tick(); cpu_rd(A_CTRL, "t5_rd_808");
        end
        tick(); cpu_rd(A_STAT, "t5_status");
        check("t5_out_valid", {31'b0, out_valid}, 32'h0);
        tick(); cpu_rd(A_DATA, "t5_data");

        // Asynchronous reset with TX holding two bytes.
        out_ready = 1'b0;
        tick(); cpu_wr(A_DATA, 32'hC1);
        tick(); cpu_wr(A_DATA, 32'hC2);
        tick();
        #1 check("t6_out_valid_before", {31'b0, out_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t6_out_valid_async", {31'b0, out_valid}, 32'h0);
        check("t6_out_data_async",  {24'b0, out_data},  32'h0);
        check("t6_in_ready_async",  {31'b0, in_ready},  32'h1);
        tx_model.delete(); rx_model.delete();
        ux_model = 1'b0; ox_model = 1'b0; ctrl_model = 3'b0;
        tick(); reset_n = 1'b1;
        tick(); cpu_rd(A_STAT, "t6_status");
        check("t6_status_const", rd, 32'h004);

`ifdef IO_PORT_IRQ_EN
        tick(); cpu_wr(A_CTRL, 32'h1);
        tick(); cpu_rd(A_CTRL, "t7_ctrl");
        check("t7_irq_idle", {31'b0, irq}, 32'h0);
        tick(); in_data = 8'h3C; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        #2 check("t7_irq_plus1", {31'b0, irq}, 32'h0);
        tick();
        #2 check("t7_irq_plus2", {31'b0, irq}, 32'h1);
        tick(); cpu_rd(A_DATA, "t7_data");
        tick();
        #2 check("t7_irq_empty_cycle", {31'b0, irq}, 32'h1);
        tick();
        #2 check("t7_irq_low", {31'b0, irq}, 32'h0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
